local_net_iface: RTL

- Network interface between a node's processing element (PE) and its mesh router's LOCAL port.
- Buffers PE-originated packets in a TX FIFO and injects them into the router. Buffers router-delivered packets in an RX FIFO for the PE.
- On PE request, drains TX and then injects one CTRL_DONE packet addressed to (0,0), so termination is ordered behind all data.

---
 rtl/local_net_iface_pkg.sv | 42 ++++
 rtl/local_net_iface_sync_fifo.sv | 68 ++++++
 rtl/local_net_iface.sv | 125 ++++++++++++
 3 files changed

// File: rtl/local_net_iface_pkg.sv
// Shared types and defaults for the mesh network interface.
// Packet layout, control codes and the termination FSM encoding live here.
package local_net_iface_pkg;

  localparam int unsigned NUM_PORTS   = 5;
  localparam int unsigned LOCAL       = 4;
  localparam int unsigned NI_TX_DEPTH = 4;
  localparam int unsigned NI_RX_DEPTH = 4;
  localparam int unsigned CoordW      = 4;
  localparam int unsigned DataW       = 32;

  typedef enum logic {
    CTRL_DATA = 1'b0,
    CTRL_DONE = 1'b1
  } ctrl_t;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
  } addr_t;

  typedef struct packed {
    ctrl_t             ctrl;
    addr_t             addr;
    logic [DataW-1:0]  data;
  } pkt_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StSendDone,
    StFinished
  } ni_state_t;

  // Termination marker always heads for the collector node at (0,0).
  localparam pkt_t DonePkt = '{ctrl: CTRL_DONE, addr: '{x: '0, y: '0}, data: '0};

  function automatic logic addr_match(addr_t a, logic [CoordW-1:0] x, logic [CoordW-1:0] y);
    return (a.x == x) && (a.y == y);
  endfunction

endpackage

// File: rtl/local_net_iface_sync_fifo.sv
// First-word fall-through packet FIFO with wrap-bit pointers and a registered count.
// Storage is not reset; only pointers and count are.
module local_net_iface_sync_fifo
  import local_net_iface_pkg::*;
#(
  parameter int unsigned Depth = 4,
  localparam int unsigned IdxW = $clog2(Depth),
  localparam int unsigned CntW = IdxW + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  pkt_t            data_i,
  input  logic            pop_i,
  output pkt_t            data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam logic [IdxW:0]   PtrOne = (IdxW + 1)'(1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  pkt_t            mem_q [Depth];
  logic [IdxW:0]   wptr_q, wptr_d;
  logic [IdxW:0]   rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[IdxW-1:0] == rptr_q[IdxW-1:0]) && (wptr_q[IdxW] != rptr_q[IdxW]);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q[IdxW-1:0]];

  // Full refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PtrOne;
    if (pop_ok)  rptr_d = rptr_q + PtrOne;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CntOne;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CntOne;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q[IdxW-1:0]] <= data_i;
  end

endmodule

// File: rtl/local_net_iface.sv
// Network interface between a PE and its router LOCAL port: TX/RX buffering plus an
// ordered termination sequence that injects a DONE packet behind all queued data.
module local_net_iface
  import local_net_iface_pkg::*;
#(
  parameter int unsigned X_POS    = 0,
  parameter int unsigned Y_POS    = 0,
  parameter int unsigned TX_DEPTH = NI_TX_DEPTH,
  parameter int unsigned RX_DEPTH = NI_RX_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      pe_tx_valid,
  output logic                      pe_tx_ready,
  input  pkt_t                      pe_tx_pkt,
  input  logic                      pe_done_req,
  output logic                      done_sent,
  output logic                      rtr_valid_out,
  input  logic                      rtr_ready_in,
  output pkt_t                      rtr_pkt_out,
  input  logic                      rtr_valid_in,
  output logic                      rtr_ready_out,
  input  pkt_t                      rtr_pkt_in,
  output logic                      pe_rx_valid,
  input  logic                      pe_rx_ready,
  output pkt_t                      pe_rx_pkt,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic                      misroute_err
);

  localparam logic [CoordW-1:0] XCoord = CoordW'(X_POS);
  localparam logic [CoordW-1:0] YCoord = CoordW'(Y_POS);

  ni_state_t state_q, state_d;
  logic      misroute_q, misroute_d;
  logic      tx_full, tx_empty, tx_push, tx_pop;
  logic      rx_full, rx_empty, rx_push, rx_pop;
  logic      send_done;
  pkt_t      tx_head;

  local_net_iface_sync_fifo #(
    .Depth (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (tx_push),
    .data_i  (pe_tx_pkt),
    .pop_i   (tx_pop),
    .data_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  local_net_iface_sync_fifo #(
    .Depth (RX_DEPTH)
  ) u_rx_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (rx_push),
    .data_i  (rtr_pkt_in),
    .pop_i   (rx_pop),
    .data_o  (pe_rx_pkt),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  // pe_done_req is only looked at in StRun, so dropping it later has no effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:      if (pe_done_req)  state_d = StDrain;
      StDrain:    if (tx_empty)     state_d = StSendDone;
      StSendDone: if (rtr_ready_in) state_d = StFinished;
      StFinished: state_d = StFinished;
      default:    state_d = StRun;
    endcase
  end

  // Router-facing valid/ready depend only on registered state to avoid comb loops.
  always_comb begin
    send_done     = (state_q == StSendDone);
    pe_tx_ready   = (state_q == StRun) && !tx_full;
    rtr_valid_out = send_done || (!tx_empty && ((state_q == StRun) || (state_q == StDrain)));
    rtr_pkt_out   = send_done ? DonePkt : tx_head;
    done_sent     = (state_q == StFinished);
  end

  assign tx_push = pe_tx_valid && pe_tx_ready;
  assign tx_pop  = rtr_valid_out && rtr_ready_in && !send_done;

  assign rtr_ready_out = !rx_full;
  assign pe_rx_valid   = !rx_empty;
  assign rx_push       = rtr_valid_in && rtr_ready_out;
  assign rx_pop        = pe_rx_valid && pe_rx_ready;

  always_comb begin
    misroute_d = misroute_q;
    if (rx_push && (rtr_pkt_in.ctrl != CTRL_DONE) &&
        !addr_match(rtr_pkt_in.addr, XCoord, YCoord)) begin
      misroute_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misroute_q <= 1'b0;
    end else begin
      misroute_q <= misroute_d;
    end
  end

  assign misroute_err = misroute_q;

endmodule
